dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of backing storage.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning the number of extra cycles between request acceptance and the memory access (range 0-15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_store_type, input, 2 bits: 00 SB, 01 SH, 10 SW, 11 reserved.
REQ-010 The block SHALL have port req_load_type, input, 3 bits: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes reserved.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: response available.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, 32 bits: load result, extended to 32 bits; 0 for stores and for errors.
REQ-015 The block SHALL have port rsp_error, output, 1 bit: the request was misaligned, out of range, or used a reserved type.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on req_valid && req_ready, with all request fields captured that cycle.
REQ-019 On acceptance, the FSM SHALL go to BUSY with wait counter = WAIT_STATES; if WAIT_STATES = 0, it SHALL go directly to RESP.
REQ-020 In BUSY, the counter SHALL decrement by 1 per cycle; on the cycle the counter equals 1, the FSM SHALL transition to RESP.
REQ-021 The memory access (read or byte-masked write) SHALL be performed on the transition into RESP, exactly once per request.
REQ-022 rsp_valid SHALL be 1 only in RESP; response fields SHALL be held stable until rsp_valid && rsp_ready, after which the FSM returns to IDLE.
REQ-023 Latency: a request accepted at cycle T SHALL produce rsp_valid at T+1+WAIT_STATES when no backpressure is applied.
REQ-024 A new request SHALL NOT be accepted in the same cycle as the response handshake; req_ready rises the following cycle.
REQ-025 Store lanes: SB SHALL write byte lane addr[1:0]; SH SHALL write lanes {addr[1],0} and {addr[1],1}; SW SHALL write all four lanes; unwritten lanes SHALL be preserved.
REQ-026 Loads: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lane(s); LW SHALL return the full word.
REQ-027 rsp_error SHALL be set for a halfword access with addr[0] = 1, a word access with addr[1:0] != 0, word index addr[31:2] >= DEPTH_WORDS, or a reserved load/store type.
REQ-028 An erroring request SHALL NOT modify memory and SHALL complete with normal timing, rsp_rdata = 0.
REQ-029 A load following a store to the same address SHALL return the stored data.

Reset
REQ-030 While rst = 0 at a clock edge, the state SHALL become IDLE, the counter 0, and rsp_valid, rsp_rdata and rsp_error 0.
REQ-031 req_ready SHALL be 0 during reset and 1 in the first cycle after reset is released.
REQ-032 If reset is asserted mid-request before the RESP transition, no memory write SHALL occur; memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 A shared package SHALL hold the load/store type encodings and the FSM state enumeration.
REQ-034 One combinational sub-module, dmem_lane_align, SHALL produce the byte-write mask, aligned write data, extended read data and the misalignment flag.

Verification
REQ-035 Scenario: WAIT_STATES=2; SW 0xDEADBEEF @0x10 accepted at T -> rsp_valid at T+3 with rsp_error=0; then LW @0x10 returns 0xDEADBEEF.
REQ-036 Scenario: SB 0x80 @0x11 over word 0x00000000 -> LB @0x11 returns 0xFFFFFF80, LBU returns 0x00000080, and LW @0x10 returns 0x00008000.
REQ-037 Scenario: LH @0x13 -> rsp_error=1 and rsp_rdata=0; SW @0x4002 -> rsp_error=1 and memory is unchanged.
REQ-038 Scenario: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; handshake -> req_ready=1 the next cycle.
REQ-039 Scenario: SW accepted, then rst=0 one cycle later -> after reset the state is IDLE with outputs 0, and a subsequent LW of that address returns the old value.
REQ-040 Scenario: WAIT_STATES=0; back-to-back requests with rsp_ready=1 -> one response every 2 cycles, in request order.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder: load/store type
// encodings, the responder FSM states, a few width constants and a helper
// that flags reserved access types.
// No ports (package).
// ----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int WORD_W     = 32;
    localparam int LANES      = WORD_W / 8;
    localparam int WAIT_CNT_W = 4;

    // Store size encodings as they arrive on req_store_type.
    typedef enum logic [1:0] {
        ST_SB   = 2'b00,
        ST_SH   = 2'b01,
        ST_SW   = 2'b10,
        ST_RSVD = 2'b11
    } store_type_e;

    // Load size/extension encodings as they arrive on req_load_type.
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_type_e;

    // Responder FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Returns 1 when the type field relevant to the access direction holds
    // an encoding that has no defined meaning.
    function automatic logic type_reserved(input logic       is_write,
                                           input logic [1:0] store_type,
                                           input logic [2:0] load_type);
        logic rsvd;
        if (is_write) begin
            rsvd = (store_type == ST_RSVD);
        end else begin
            case (load_type)
                LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: rsvd = 1'b0;
                default:                             rsvd = 1'b1;
            endcase
        end
        return rsvd;
    endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the data-memory responder.
// Stores: produces the per-lane write mask and the store data replicated so
// that every enabled lane sees the right bytes.
// Loads: picks the addressed byte/halfword out of the memory word and sign-
// or zero-extends it to 32 bits.
// Also reports whether the access is misaligned for its size.
//
// Ports:
//   byte_off    in  [1:0]  low address bits (byte position inside the word)
//   is_write    in         1 = store, 0 = load
//   store_type  in  [1:0]  store size encoding
//   load_type   in  [2:0]  load size/extension encoding
//   store_data  in  [31:0] right-aligned store data
//   mem_word    in  [31:0] current contents of the addressed word
//   byte_mask   out [3:0]  lanes a store would write
//   write_word  out [31:0] store data positioned on its lanes
//   load_data   out [31:0] extended load result
//   misaligned  out        access crosses its natural alignment
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]        byte_off,
    input  logic              is_write,
    input  logic [1:0]        store_type,
    input  logic [2:0]        load_type,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] mem_word,
    output logic [LANES-1:0]  byte_mask,
    output logic [WORD_W-1:0] write_word,
    output logic [WORD_W-1:0] load_data,
    output logic              misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // The addressed byte and halfword are extracted once; a halfword is
    // chosen by addr[1] alone because a legal halfword never has addr[0]=1.
    always_comb begin
        sel_byte = mem_word[{byte_off, 3'b000} +: 8];
        sel_half = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Store path: the data is replicated across all lanes so only the mask
    // decides which bytes land in memory. Load path: extend the selection.
    always_comb begin
        byte_mask  = '0;
        write_word = '0;
        load_data  = '0;
        misaligned = 1'b0;
        if (is_write) begin
            case (store_type)
                ST_SB: begin
                    byte_mask  = 4'b0001 << byte_off;
                    write_word = {4{store_data[7:0]}};
                end
                ST_SH: begin
                    byte_mask  = byte_off[1] ? 4'b1100 : 4'b0011;
                    write_word = {2{store_data[15:0]}};
                    misaligned = byte_off[0];
                end
                ST_SW: begin
                    byte_mask  = 4'b1111;
                    write_word = store_data;
                    misaligned = |byte_off;
                end
                default: begin
                    byte_mask  = '0;
                end
            endcase
        end else begin
            case (load_type)
                LD_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
                LD_LBU: load_data = {24'h000000, sel_byte};
                LD_LH: begin
                    load_data  = {{16{sel_half[15]}}, sel_half};
                    misaligned = byte_off[0];
                end
                LD_LHU: begin
                    load_data  = {16'h0000, sel_half};
                    misaligned = byte_off[0];
                end
                LD_LW: begin
                    load_data  = mem_word;
                    misaligned = |byte_off;
                end
                default: begin
                    load_data = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Word-organised data memory behind a valid/ready request channel and a
// valid/ready response channel. Each accepted request waits WAIT_STATES
// cycles, then performs its single memory access while entering RESP and
// holds the response until the initiator takes it.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words of storage
//   WAIT_STATES  extra cycles between acceptance and the access (0-15)
//
// Ports:
//   clk             in         rising-edge clock
//   rst             in         synchronous active-low reset
//   req_valid       in         request present
//   req_ready       out        request accepted this cycle (IDLE only)
//   req_addr        in  [31:0] byte address
//   req_write       in         1 = store, 0 = load
//   req_store_type  in  [1:0]  SB/SH/SW/reserved
//   req_load_type   in  [2:0]  LB/LH/LW/LBU/LHU, others reserved
//   req_wdata       in  [31:0] right-aligned store data
//   rsp_valid       out        response present (RESP only)
//   rsp_ready       in         initiator accepts the response
//   rsp_rdata       out [31:0] extended load data, 0 for stores/errors
//   rsp_error       out        misaligned, out of range or reserved type
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [1:0]        req_store_type,
    input  logic [2:0]        req_load_type,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Backing storage; deliberately never reset.
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WORD_W-1:0]     addr_q, addr_d;
    logic                  write_q, write_d;
    logic [1:0]            store_type_q, store_type_d;
    logic [2:0]            load_type_q, load_type_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    logic                  accept;
    logic                  enter_resp;
    logic [WORD_W-1:0]     acc_addr;
    logic                  acc_write;
    logic [1:0]            acc_store_type;
    logic [2:0]            acc_load_type;
    logic [WORD_W-1:0]     acc_wdata;
    logic [IDX_W-1:0]      acc_idx;
    logic [WORD_W-1:0]     mem_word;
    logic [LANES-1:0]      byte_mask;
    logic [WORD_W-1:0]     write_word;
    logic [WORD_W-1:0]     load_data;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  bad_type;
    logic                  access_error;

    assign accept = req_valid && req_ready_q;

    // With zero wait states the access happens on the acceptance edge, before
    // the request fields are registered, so the live request is used then.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr       = req_addr;
            acc_write      = req_write;
            acc_store_type = req_store_type;
            acc_load_type  = req_load_type;
            acc_wdata      = req_wdata;
        end else begin
            acc_addr       = addr_q;
            acc_write      = write_q;
            acc_store_type = store_type_q;
            acc_load_type  = load_type_q;
            acc_wdata      = wdata_q;
        end
    end

    // Word index and error classification for the access being performed.
    always_comb begin
        acc_idx      = acc_addr[IDX_W+1:2];
        mem_word     = mem[acc_idx];
        out_of_range = ({2'b00, acc_addr[WORD_W-1:2]} >= WORD_W'(DEPTH_WORDS));
        bad_type     = type_reserved(acc_write, acc_store_type, acc_load_type);
        access_error = misaligned || out_of_range || bad_type;
    end

    dmem_lane_align u_lane_align (
        .byte_off   (acc_addr[1:0]),
        .is_write   (acc_write),
        .store_type (acc_store_type),
        .load_type  (acc_load_type),
        .store_data (acc_wdata),
        .mem_word   (mem_word),
        .byte_mask  (byte_mask),
        .write_word (write_word),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // The single cycle on which the access happens: the edge that moves the
    // FSM into RESP, either straight from IDLE or when the countdown ends.
    always_comb begin
        enter_resp = 1'b0;
        if (state_q == S_IDLE) begin
            enter_resp = accept && (WAIT_STATES == 0);
        end else if (state_q == S_BUSY) begin
            enter_resp = (wait_cnt_q == WAIT_CNT_W'(1));
        end
    end

    // Next-state logic. The response fields are loaded only when entering
    // RESP and otherwise hold, which keeps them stable under backpressure.
    // req_ready/rsp_valid are registered copies of the next state so they
    // come straight from flops.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        addr_d       = addr_q;
        write_d      = write_q;
        store_type_d = store_type_q;
        load_type_d  = load_type_q;
        wdata_d      = wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_error_d  = rsp_error_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d       = req_addr;
                    write_d      = req_write;
                    store_type_d = req_store_type;
                    load_type_d  = req_load_type;
                    wdata_d      = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = S_BUSY;
                        wait_cnt_d = WAIT_CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_BUSY: begin
                wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                if (enter_resp) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            rsp_error_d = access_error;
            rsp_rdata_d = (access_error || acc_write) ? '0 : load_data;
        end

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and output registers. Reset forces IDLE with quiet outputs and
    // drops req_ready so nothing is accepted while reset is applied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            store_type_q <= '0;
            load_type_q  <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            store_type_q <= store_type_d;
            load_type_q  <= load_type_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    // Byte-masked store, once per request. Gating on rst means a reset that
    // lands on the access edge also suppresses the write; erroring requests
    // never touch memory.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && acc_write && !access_error) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_mask[b]) begin
                    mem[acc_idx][8*b +: 8] <= write_word[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. A WAIT_STATES=2 instance is driven
// through a table of directed vectors, hand-written backpressure and reset
// sequences, and randomized requests checked against a byte-array model.
// A second WAIT_STATES=0 instance is streamed back-to-back requests.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH        = 1024;
    localparam int WAITS        = 2;
    localparam int REGION_BYTES = 256;
    localparam int MAX_WAIT     = 50;
    localparam int NUM_RANDOM   = 200;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [1:0]  req_store_type = '0;
    logic [2:0]  req_load_type = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    logic        zReqValid = 1'b0;
    logic        zReqReady;
    logic [31:0] zReqAddr = '0;
    logic        zReqWrite = 1'b0;
    logic [1:0]  zReqSt = '0;
    logic [2:0]  zReqLt = '0;
    logic [31:0] zReqWdata = '0;
    logic        zRspValid;
    logic [31:0] zRspRdata;
    logic        zRspError;

    int checks = 0;
    int failures = 0;

    logic [7:0] modelMem [DEPTH*4];
    vec_t vecs[$];
    vec_t zVecs[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WAITS)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_store_type (req_store_type),
        .req_load_type  (req_load_type),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dutZero (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (zReqValid),
        .req_ready      (zReqReady),
        .req_addr       (zReqAddr),
        .req_write      (zReqWrite),
        .req_store_type (zReqSt),
        .req_load_type  (zReqLt),
        .req_wdata      (zReqWdata),
        .rsp_valid      (zRspValid),
        .rsp_ready      (1'b1),
        .rsp_rdata      (zRspRdata),
        .rsp_error      (zRspError)
    );

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Reference behaviour from the architectural rules: size and alignment
    // checks with arithmetic, little-endian bytes kept in a flat array.
    function automatic void refModel(input logic [31:0] addr, input logic write,
                                     input logic [1:0] st, input logic [2:0] lt,
                                     input logic [31:0] wdata,
                                     output logic [31:0] expRdata, output logic expErr);
        int size;
        bit isSigned;
        bit reserved;
        int base;
        logic [31:0] value;
        size = 0;
        isSigned = 0;
        reserved = 0;
        if (write) begin
            case (st)
                2'd0: size = 1;
                2'd1: size = 2;
                2'd2: size = 4;
                default: reserved = 1;
            endcase
        end else begin
            case (lt)
                3'd0: begin size = 1; isSigned = 1; end
                3'd1: begin size = 2; isSigned = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: reserved = 1;
            endcase
        end
        expRdata = 32'h0;
        if (reserved) begin
            expErr = 1'b1;
        end else begin
            expErr = ((addr % size) != 0) || ((addr / 4) >= DEPTH);
        end
        if (!expErr) begin
            base = int'(addr);
            if (write) begin
                for (int i = 0; i < size; i++) modelMem[base + i] = wdata[8*i +: 8];
            end else begin
                value = 32'h0;
                for (int i = 0; i < size; i++) value = value | (32'(modelMem[base + i]) << (8*i));
                if (isSigned && size == 1) value = {{24{value[7]}}, value[7:0]};
                if (isSigned && size == 2) value = {{16{value[15]}}, value[15:0]};
                expRdata = value;
            end
        end
    endfunction

    // Present a request and wait (bounded) until it is accepted.
    task automatic sendRequest(input logic [31:0] addr, input logic write, input logic [1:0] st,
                               input logic [2:0] lt, input logic [31:0] wdata, output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = addr;
        req_write = write;
        req_store_type = st;
        req_load_type = lt;
        req_wdata = wdata;
        while (!req_ready && guard < MAX_WAIT) begin
            @(negedge clk);
            guard++;
        end
        ok = req_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=no_accept expected=accept within %0d cycles", MAX_WAIT);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count cycles after the acceptance edge until rsp_valid (bounded).
    task automatic waitResponse(output int lat, output bit ok);
        lat = 0;
        while (!rsp_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = rsp_valid;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL response_timeout actual=no_rsp_valid expected=rsp_valid within %0d cycles", MAX_WAIT);
        end
    endtask

    // One full transaction with rsp_ready held high.
    task automatic applyStimulus(input logic [31:0] addr, input logic write, input logic [1:0] st,
                                 input logic [2:0] lt, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat, output bit ok);
        rdata = 'x;
        err = 'x;
        lat = -1;
        sendRequest(addr, write, st, lt, wdata, ok);
        if (!ok) return;
        waitResponse(lat, ok);
        if (!ok) return;
        rdata = rsp_rdata;
        err = rsp_error;
        @(posedge clk);
        #1;
    endtask

    // Run one request and check data, error and latency against expectations.
    task automatic runChecked(input string tag, input logic [31:0] addr, input logic write,
                              input logic [1:0] st, input logic [2:0] lt, input logic [31:0] wdata,
                              input logic [31:0] expRdata, input logic expErr);
        logic [31:0] rdata;
        logic err;
        int lat;
        bit ok;
        applyStimulus(addr, write, st, lt, wdata, rdata, err, lat, ok);
        if (!ok) return;
        checkOutput({tag, "_rdata"}, rdata, expRdata);
        checkOutput({tag, "_error"}, 32'(err), 32'(expErr));
        checkOutput({tag, "_latency"}, 32'(lat + 1), 32'(1 + WAITS));
    endtask

    task automatic addVec(ref vec_t q[$], input logic [31:0] addr, input logic write, input logic [1:0] st,
                          input logic [2:0] lt, input logic [31:0] wdata,
                          input logic [31:0] expRdata, input logic expErr);
        vec_t v;
        v.addr = addr; v.write = write; v.st = st; v.lt = lt;
        v.wdata = wdata; v.expRdata = expRdata; v.expErr = expErr;
        q.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] mRdata;
        logic        mErr;
        logic [31:0] rA, rW;
        logic        rWr;
        logic [1:0]  rSt;
        logic [2:0]  rLt;
        bit          ok;
        int          lat;
        int          cyc, nextReq, nResp, lastRespCyc;
        bit          accepted;

        // Directed vectors; memory 0..255 is zeroed before these run.
        addVec(vecs, 32'h10,   1, 2'b10, 3'b000, 32'hDEADBEEF, 32'h0,        0);
        addVec(vecs, 32'h10,   0, 2'b00, 3'b010, 32'h0,        32'hDEADBEEF, 0);
        addVec(vecs, 32'h10,   1, 2'b10, 3'b000, 32'h0,        32'h0,        0);
        addVec(vecs, 32'h11,   1, 2'b00, 3'b000, 32'h00000080, 32'h0,        0);
        addVec(vecs, 32'h11,   0, 2'b00, 3'b000, 32'h0,        32'hFFFFFF80, 0);
        addVec(vecs, 32'h11,   0, 2'b00, 3'b100, 32'h0,        32'h00000080, 0);
        addVec(vecs, 32'h10,   0, 2'b00, 3'b010, 32'h0,        32'h00008000, 0);
        addVec(vecs, 32'h13,   0, 2'b00, 3'b001, 32'h0,        32'h0,        1);
        addVec(vecs, 32'h4002, 1, 2'b10, 3'b000, 32'h12345678, 32'h0,        1);
        addVec(vecs, 32'h10,   0, 2'b00, 3'b010, 32'h0,        32'h00008000, 0);
        addVec(vecs, 32'h12,   1, 2'b01, 3'b000, 32'h5555ABCD, 32'h0,        0);
        addVec(vecs, 32'h10,   0, 2'b00, 3'b010, 32'h0,        32'hABCD8000, 0);
        addVec(vecs, 32'h12,   0, 2'b00, 3'b001, 32'h0,        32'hFFFFABCD, 0);
        addVec(vecs, 32'h12,   0, 2'b00, 3'b101, 32'h0,        32'h0000ABCD, 0);
        addVec(vecs, 32'h13,   0, 2'b00, 3'b000, 32'h0,        32'hFFFFFFAB, 0);
        addVec(vecs, 32'h10,   0, 2'b00, 3'b011, 32'h0,        32'h0,        1);
        addVec(vecs, 32'h10,   1, 2'b11, 3'b000, 32'hFFFFFFFF, 32'h0,        1);
        addVec(vecs, 32'h10,   0, 2'b00, 3'b110, 32'h0,        32'h0,        1);
        addVec(vecs, 32'h10,   0, 2'b00, 3'b010, 32'h0,        32'hABCD8000, 0);
        addVec(vecs, 32'hFFC,  1, 2'b10, 3'b000, 32'hCAFEF00D, 32'h0,        0);
        addVec(vecs, 32'hFFC,  0, 2'b00, 3'b010, 32'h0,        32'hCAFEF00D, 0);
        addVec(vecs, 32'h1000, 0, 2'b00, 3'b010, 32'h0,        32'h0,        1);
        addVec(vecs, 32'h4000, 1, 2'b00, 3'b000, 32'h000000AA, 32'h0,        1);
        addVec(vecs, 32'h21,   1, 2'b01, 3'b000, 32'h00001234, 32'h0,        1);
        addVec(vecs, 32'h16,   1, 2'b10, 3'b000, 32'h77777777, 32'h0,        1);
        addVec(vecs, 32'h20,   0, 2'b00, 3'b010, 32'h0,        32'h0,        0);
        addVec(vecs, 32'h14,   0, 2'b00, 3'b010, 32'h0,        32'h0,        0);

        // Reset state: quiet outputs and no ready while reset is held.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_error", 32'(rsp_error), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_req_ready", 32'(req_ready), 32'h1);

        // Known contents for the random region.
        for (int w = 0; w < REGION_BYTES / 4; w++) begin
            refModel(32'(w * 4), 1'b1, 2'b10, 3'b000, 32'h0, mRdata, mErr);
            runChecked("init", 32'(w * 4), 1'b1, 2'b10, 3'b000, 32'h0, mRdata, mErr);
        end

        // Directed table.
        foreach (vecs[i]) begin
            refModel(vecs[i].addr, vecs[i].write, vecs[i].st, vecs[i].lt, vecs[i].wdata, mRdata, mErr);
            runChecked($sformatf("vec%0d", i), vecs[i].addr, vecs[i].write, vecs[i].st, vecs[i].lt,
                       vecs[i].wdata, vecs[i].expRdata, vecs[i].expErr);
        end

        // Backpressure: response held for 5 cycles, stable, no new acceptance.
        rsp_ready = 1'b0;
        sendRequest(32'h10, 1'b0, 2'b00, 3'b010, 32'h0, ok);
        if (ok) begin
            waitResponse(lat, ok);
            if (ok) begin
                checkOutput("bp_first_rdata", rsp_rdata, 32'hABCD8000);
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    checkOutput("bp_hold_valid", 32'(rsp_valid), 32'h1);
                    checkOutput("bp_hold_rdata", rsp_rdata, 32'hABCD8000);
                    checkOutput("bp_hold_req_ready", 32'(req_ready), 32'h0);
                end
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("bp_after_hs_valid", 32'(rsp_valid), 32'h0);
                checkOutput("bp_after_hs_req_ready", 32'(req_ready), 32'h1);
            end
        end
        rsp_ready = 1'b1;

        // Reset one cycle after a store is accepted: the store must vanish.
        sendRequest(32'h20, 1'b1, 2'b10, 3'b000, 32'h12345678, ok);
        if (ok) begin
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
            checkOutput("midreset_rsp_rdata", rsp_rdata, 32'h0);
            checkOutput("midreset_rsp_error", 32'(rsp_error), 32'h0);
            checkOutput("midreset_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("midreset_release_req_ready", 32'(req_ready), 32'h1);
            checkOutput("midreset_release_rsp_valid", 32'(rsp_valid), 32'h0);
            repeat (3) @(posedge clk);
            refModel(32'h20, 1'b0, 2'b00, 3'b010, 32'h0, mRdata, mErr);
            runChecked("midreset_old_value", 32'h20, 1'b0, 2'b00, 3'b010, 32'h0, mRdata, mErr);
        end

        // Randomized requests against the model.
        for (int n = 0; n < NUM_RANDOM; n++) begin
            if ($urandom_range(0, 7) == 0) rA = 32'h4000 + 32'($urandom_range(0, 255));
            else rA = 32'($urandom_range(0, REGION_BYTES - 1));
            rWr = 1'($urandom_range(0, 1));
            rSt = 2'($urandom_range(0, 3));
            rLt = 3'($urandom_range(0, 7));
            rW = $urandom;
            refModel(rA, rWr, rSt, rLt, rW, mRdata, mErr);
            runChecked($sformatf("rand%0d", n), rA, rWr, rSt, rLt, rW, mRdata, mErr);
        end

        // Zero wait states, requests streamed back to back.
        addVec(zVecs, 32'h0, 1, 2'b10, 3'b000, 32'h11111111, 32'h0,        0);
        addVec(zVecs, 32'h4, 1, 2'b10, 3'b000, 32'h22222222, 32'h0,        0);
        addVec(zVecs, 32'h0, 0, 2'b00, 3'b010, 32'h0,        32'h11111111, 0);
        addVec(zVecs, 32'h4, 0, 2'b00, 3'b010, 32'h0,        32'h22222222, 0);
        addVec(zVecs, 32'h6, 0, 2'b00, 3'b101, 32'h0,        32'h00002222, 0);
        cyc = 0;
        nextReq = 0;
        nResp = 0;
        lastRespCyc = -1;
        zReqValid = 1'b1;
        zReqAddr = zVecs[0].addr; zReqWrite = zVecs[0].write; zReqSt = zVecs[0].st;
        zReqLt = zVecs[0].lt; zReqWdata = zVecs[0].wdata;
        while (nResp < zVecs.size() && cyc < 60) begin
            @(negedge clk);
            if (zRspValid) begin
                checkOutput($sformatf("ws0_rdata%0d", nResp), zRspRdata, zVecs[nResp].expRdata);
                checkOutput($sformatf("ws0_error%0d", nResp), 32'(zRspError), 32'(zVecs[nResp].expErr));
                if (nResp > 0) checkOutput("ws0_spacing", 32'(cyc - lastRespCyc), 32'h2);
                lastRespCyc = cyc;
                nResp++;
            end
            accepted = zReqValid && zReqReady;
            @(posedge clk);
            #1;
            cyc++;
            if (accepted) begin
                nextReq++;
                if (nextReq < zVecs.size()) begin
                    zReqAddr = zVecs[nextReq].addr; zReqWrite = zVecs[nextReq].write;
                    zReqSt = zVecs[nextReq].st; zReqLt = zVecs[nextReq].lt;
                    zReqWdata = zVecs[nextReq].wdata;
                end else begin
                    zReqValid = 1'b0;
                end
            end
        end
        checkOutput("ws0_response_count", 32'(nResp), 32'(zVecs.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
